alu_operand_regfile: RTL and testbench
======================================

Name: alu_operand_regfile

Overview:
- Upstream feeder of the single-cycle datapath ALU. Holds the 32 x 32-bit general register file and produces the ALU's A and B operands in the same cycle.
- A is always register read port 1.
- B is either register read port 2 or the extended 16-bit immediate, selected by alusrc.
- Read port 2 is also exported raw as store data.
- The only sequential element is the register array; writeback arrives from the ALU/memory result path.

Parameters:
DATA_W, 32, register and operand width
ADDR_W, 5, register address width
NREGS, 32, number of registers (2**ADDR_W)
IMM_W, 16, immediate field width

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high; clears all registers
ra1  input  ADDR_W  read address, port 1 (rs)
ra2  input  ADDR_W  read address, port 2 (rt)
we  input  1  write enable
wa  input  ADDR_W  write address
wd  input  DATA_W  write data (writeback result)
imm  input  IMM_W  instruction immediate field
signext  input  1  1 = sign-extend imm, 0 = zero-extend
alusrc  input  1  0 = B from port 2, 1 = B from extended imm
A  output  DATA_W  ALU operand A
B  output  DATA_W  ALU operand B
rd2  output  DATA_W  raw read port 2 (store data)

Behaviour:
- One clock. Reset is synchronous and active-high. All register state updates only on the rising edge of clk.
- Reset:
  - On a clock edge with reset=1, all NREGS registers become 0.
  - Reset dominates we; any write presented that cycle is discarded.
  - A, B and rd2 are combinational. After reset they read 0, or the extended immediate on B when alusrc=1.
- Write:
  - At the edge, if reset=0, we=1 and wa!=0, then reg[wa] <= wd.
  - Writes to register 0 are ignored. Register 0 always reads 0.
- Read:
  - Reads are combinational and asynchronous.
  - A = (ra1==0) ? 0 : reg[ra1].
  - rd2 = (ra2==0) ? 0 : reg[ra2].
- Immediate extension:
  - ext = signext ? {{16{imm[15]}}, imm} : {16'b0, imm}.
- B = alusrc ? ext : rd2. rd2 is unaffected by alusrc.
- Same-cycle write/read to the same register, without bypass: a read returns the pre-edge (old) value; the new value is visible after the edge.
- Two reads of the same address return identical values on both ports.
- X on unused inputs (imm when alusrc=0, wd when we=0) must not propagate to the outputs.
- Latency:
  - Read-to-output is 0 cycles (combinational).
  - Write-to-visible is 1 edge.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined:
  - Write-through forwarding.
  - If we=1, wa!=0 and wa==ra1, then A = wd in the same cycle. Likewise rd2 (and B when alusrc=0) = wd when wa==ra2.
  - Reset=1 suppresses the bypass, so reads show stored/zero values.
  - Register 0 is never bypassed.
- Undefined: no forwarding; reads return stored values as described in Behaviour.

Decomposition:
- Shared package datapath_pkg:
  - DATA_W, ADDR_W, IMM_W.
  - Constants ALUSRC_REG=1'b0, ALUSRC_IMM=1'b1.
  - Constants EXT_ZERO=1'b0, EXT_SIGN=1'b1.
  - REG_ZERO=5'd0.
- One natural sub-module, imm_extend: combinational imm/signext -> ext. The register array and B mux stay in the top.

Test Plan:
- Reset clears: write 0xDEADBEEF to r5, then pulse reset one cycle. ra1=5 -> A=0x00000000.
- Write/read: we=1, wa=7, wd=0x12345678, one edge; then ra1=7, ra2=7 -> A=rd2=B=0x12345678 (alusrc=0).
- r0 hardwired: we=1, wa=0, wd=0xFFFFFFFF, edge; ra1=0 -> A=0.
- Immediate:
  - alusrc=1, imm=0x8001, signext=1 -> B=0xFFFF8001; signext=0 -> B=0x00008001.
  - rd2 still shows reg[ra2].
- Same-cycle hazard:
  - r3=0x11 stored; in the cycle we=1, wa=3, wd=0x22, ra1=3.
  - Without REGFILE_BYPASS_EN: A=0x11 before the edge, 0x22 after.
  - With it: A=0x22 before the edge.
- Reset vs write: reset=1 and we=1, wa=4, wd=0xAA in the same cycle -> after the edge reg4 reads 0.

Source files
------------

// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared datapath widths and operand-select constants
//
// Purpose: widths and encodings shared by the operand register file and its
// immediate extender.
// Ports: none (package).
package datapath_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int IMM_W  = 16;
  localparam int NREGS  = 1 << ADDR_W;

  // B operand source select
  localparam logic ALUSRC_REG = 1'b0;
  localparam logic ALUSRC_IMM = 1'b1;

  // Immediate extension mode
  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/imm_extend.sv
// rtl/imm_extend.sv - combinational 16-to-32-bit immediate extender
//
// Purpose: widens the instruction immediate to the datapath width.
// Ports:
//   imm     in  IMM_W   instruction immediate field
//   signext in  1       EXT_SIGN = replicate imm MSB, EXT_ZERO = zero fill
//   ext     out DATA_W  extended immediate
module imm_extend
  import datapath_pkg::*;
(
  input  logic [IMM_W-1:0]  imm,
  input  logic              signext,
  output logic [DATA_W-1:0] ext
);

  always_comb begin
    if (signext == EXT_SIGN) begin
      ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    end else begin
      ext = {{(DATA_W-IMM_W){1'b0}}, imm};
    end
  end

endmodule

// File: rtl/alu_operand_regfile.sv
// rtl/alu_operand_regfile.sv - 32x32 register file producing ALU operands A/B
//
// Purpose: general register file feeding the single-cycle ALU. A comes from
// read port 1; B is read port 2 or the extended immediate; read port 2 is
// also exported raw as store data. Register 0 is hardwired to zero.
// Configuration: define REGFILE_BYPASS_EN to forward same-cycle write data
// to the read ports (write-through); default build has no forwarding.
// Ports:
//   clk      in  1       rising-edge clock
//   reset    in  1       synchronous active-high, clears all registers
//   ra1/ra2  in  ADDR_W  read addresses (rs / rt)
//   we/wa/wd in          writeback enable / address / data
//   imm      in  IMM_W   immediate field
//   signext  in  1       1 = sign-extend imm, 0 = zero-extend
//   alusrc   in  1       0 = B from port 2, 1 = B from extended imm
//   A, B     out DATA_W  ALU operands
//   rd2      out DATA_W  raw read port 2 (store data)
module alu_operand_regfile
  import datapath_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [IMM_W-1:0]  imm,
  input  logic              signext,
  input  logic              alusrc,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] rd2
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [DATA_W-1:0] ext;
  logic              wr_en;

  // Writes to r0 are dropped here so the stored r0 stays zero as well.
  assign wr_en = we && (wa != REG_ZERO);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[wa] = wd;
    end
  end

  // Reset takes priority over any write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    A   = (ra1 == REG_ZERO) ? '0 : regs_q[ra1];
    rd2 = (ra2 == REG_ZERO) ? '0 : regs_q[ra2];
`ifdef REGFILE_BYPASS_EN
    // Forwarding is suppressed during reset; wr_en already excludes r0.
    if (!reset && wr_en && (wa == ra1)) begin
      A = wd;
    end
    if (!reset && wr_en && (wa == ra2)) begin
      rd2 = wd;
    end
`endif
  end

  imm_extend u_imm_extend (
    .imm     (imm),
    .signext (signext),
    .ext     (ext)
  );

  assign B = (alusrc == ALUSRC_IMM) ? ext : rd2;

endmodule

// File: tb/tb_alu_operand_regfile.sv
// tb/tb_alu_operand_regfile.sv - directed self-checking bench for alu_operand_regfile
module tb_alu_operand_regfile;

  logic        clk;
  logic        reset;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [15:0] imm;
  logic        signext;
  logic        alusrc;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] rd2;

  int n_cmp;
  int n_bad;

  alu_operand_regfile dut (
    .clk     (clk),
    .reset   (reset),
    .ra1     (ra1),
    .ra2     (ra2),
    .we      (we),
    .wa      (wa),
    .wd      (wd),
    .imm     (imm),
    .signext (signext),
    .alusrc  (alusrc),
    .A       (A),
    .B       (B),
    .rd2     (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    tick();
    we = 1'b0; wd = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ra1 = 5'd5; ra2 = 5'd31; alusrc = 1'b0; #1;
    n_cmp++; if (A !== 32'h0) begin n_bad++; $display("FAIL reset_A got=%h exp=%h", A, 32'h0); end
    n_cmp++; if (rd2 !== 32'h0) begin n_bad++; $display("FAIL reset_rd2 got=%h exp=%h", rd2, 32'h0); end
    alusrc = 1'b1; imm = 16'h1234; signext = 1'b1; #1;
    n_cmp++; if (B !== 32'h00001234) begin n_bad++; $display("FAIL reset_B_imm got=%h exp=%h", B, 32'h00001234); end
    alusrc = 1'b0;
    write_reg(5'd5, 32'hDEADBEEF);
    #1;
    n_cmp++; if (A !== 32'hDEADBEEF) begin n_bad++; $display("FAIL r5_written got=%h exp=%h", A, 32'hDEADBEEF); end
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    n_cmp++; if (A !== 32'h0) begin n_bad++; $display("FAIL r5_cleared got=%h exp=%h", A, 32'h0); end
  endtask

  task automatic test_write_read();
    write_reg(5'd7, 32'h12345678);
    ra1 = 5'd7; ra2 = 5'd7; alusrc = 1'b0; #1;
    n_cmp++; if (A !== 32'h12345678) begin n_bad++; $display("FAIL wr_A got=%h exp=%h", A, 32'h12345678); end
    n_cmp++; if (rd2 !== 32'h12345678) begin n_bad++; $display("FAIL wr_rd2 got=%h exp=%h", rd2, 32'h12345678); end
    n_cmp++; if (B !== 32'h12345678) begin n_bad++; $display("FAIL wr_B got=%h exp=%h", B, 32'h12345678); end
  endtask

  task automatic test_r0();
    write_reg(5'd0, 32'hFFFFFFFF);
    ra1 = 5'd0; ra2 = 5'd0; alusrc = 1'b0; #1;
    n_cmp++; if (A !== 32'h0) begin n_bad++; $display("FAIL r0_A got=%h exp=%h", A, 32'h0); end
    n_cmp++; if (rd2 !== 32'h0) begin n_bad++; $display("FAIL r0_rd2 got=%h exp=%h", rd2, 32'h0); end
`ifdef REGFILE_BYPASS_EN
    // r0 must not be forwarded either
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; #1;
    n_cmp++; if (A !== 32'h0) begin n_bad++; $display("FAIL r0_nobypass got=%h exp=%h", A, 32'h0); end
    we = 1'b0;
`endif
  endtask

  task automatic test_imm();
    write_reg(5'd9, 32'hCAFEF00D);
    ra2 = 5'd9; alusrc = 1'b1; imm = 16'h8001; signext = 1'b1; #1;
    n_cmp++; if (B !== 32'hFFFF8001) begin n_bad++; $display("FAIL imm_sext got=%h exp=%h", B, 32'hFFFF8001); end
    n_cmp++; if (rd2 !== 32'hCAFEF00D) begin n_bad++; $display("FAIL imm_rd2 got=%h exp=%h", rd2, 32'hCAFEF00D); end
    signext = 1'b0; #1;
    n_cmp++; if (B !== 32'h00008001) begin n_bad++; $display("FAIL imm_zext got=%h exp=%h", B, 32'h00008001); end
    imm = 16'h7FFF; signext = 1'b1; #1;
    n_cmp++; if (B !== 32'h00007FFF) begin n_bad++; $display("FAIL imm_sext_pos got=%h exp=%h", B, 32'h00007FFF); end
    // imm is X but unused when alusrc selects the register
    alusrc = 1'b0; imm = 16'hxxxx; #1;
    n_cmp++; if (B !== 32'hCAFEF00D) begin n_bad++; $display("FAIL imm_x_blocked got=%h exp=%h", B, 32'hCAFEF00D); end
    imm = 16'h0;
  endtask

  task automatic test_hazard();
    write_reg(5'd3, 32'h11);
    we = 1'b1; wa = 5'd3; wd = 32'h22; ra1 = 5'd3; ra2 = 5'd3; alusrc = 1'b0; #1;
`ifdef REGFILE_BYPASS_EN
    n_cmp++; if (A !== 32'h22) begin n_bad++; $display("FAIL hz_A_pre got=%h exp=%h", A, 32'h22); end
    n_cmp++; if (B !== 32'h22) begin n_bad++; $display("FAIL hz_B_pre got=%h exp=%h", B, 32'h22); end
`else
    n_cmp++; if (A !== 32'h11) begin n_bad++; $display("FAIL hz_A_pre got=%h exp=%h", A, 32'h11); end
    n_cmp++; if (B !== 32'h11) begin n_bad++; $display("FAIL hz_B_pre got=%h exp=%h", B, 32'h11); end
`endif
    tick();
    we = 1'b0; #1;
    n_cmp++; if (A !== 32'h22) begin n_bad++; $display("FAIL hz_A_post got=%h exp=%h", A, 32'h22); end
  endtask

  task automatic test_reset_vs_write();
    write_reg(5'd4, 32'h55);
    reset = 1'b1; we = 1'b1; wa = 5'd4; wd = 32'hAA; ra1 = 5'd4; #1;
    // stored value shows before the edge: reset suppresses any forwarding
    n_cmp++; if (A !== 32'h55) begin n_bad++; $display("FAIL rvw_pre got=%h exp=%h", A, 32'h55); end
    tick();
    reset = 1'b0; we = 1'b0; #1;
    n_cmp++; if (A !== 32'h0) begin n_bad++; $display("FAIL rvw_post got=%h exp=%h", A, 32'h0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [4];
    exp[0] = 32'hA0A0A0A0; exp[1] = 32'h0000FFFF; exp[2] = 32'h80000000; exp[3] = 32'h00000001;
    for (int i = 0; i < 4; i++) begin
      we = 1'b1; wa = 5'(10 + i); wd = exp[i];
      tick();
    end
    we = 1'b0;
    // write disabled with X data must change nothing
    wa = 5'd10; wd = 32'hxxxxxxxx;
    tick();
    wd = 32'h0;
    alusrc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ra1 = 5'(10 + i); ra2 = 5'(13 - i); #1;
      n_cmp++; if (A !== exp[i]) begin n_bad++; $display("FAIL b2b_A[%0d] got=%h exp=%h", i, A, exp[i]); end
      n_cmp++; if (rd2 !== exp[3-i]) begin n_bad++; $display("FAIL b2b_rd2[%0d] got=%h exp=%h", i, rd2, exp[3-i]); end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1; ra1 = '0; ra2 = '0; we = 1'b0; wa = '0; wd = '0;
    imm = '0; signext = 1'b0; alusrc = 1'b0;
    #2;
    test_reset();
    test_write_read();
    test_r0();
    test_imm();
    test_hazard();
    test_reset_vs_write();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
